bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 algorithm, one bit per clock. It replaces the fully unrolled combinational converter in front of the seven-segment display driver where wide inputs or many digits make the unrolled adder chain too deep. The block adds a start/done handshake, registered and held outputs, an overflow flag and a leading-zero mask for display blanking.

## Interface
- WIDTH, 11: binary input width, ≥1.
- DIGITS, 4: number of BCD output digits, ≥1.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- bin  in  WIDTH  unsigned value; captured on the accepting edge, may change afterwards.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bcd/ovf/lz_mask valid and updated in this cycle.
- bcd  out  4*DIGITS  packed result; digit i at bits [4i+3:4i], digit 0 = units.
- ovf  out  1  bin ≥ 10^DIGITS; bcd then holds bin mod 10^DIGITS.
- lz_mask  out  DIGITS  bit i (i≥1) set when digit i and all higher digits are 0; bit 0 always 0.

## Operation
- Internal shift register SR of 4*DIGITS+WIDTH bits: upper 4*DIGITS = BCD accumulator, lower WIDTH = binary. Bit counter cnt, width clog2(WIDTH+1). Sticky overflow flag ovf_r.
- States: IDLE, SHIFT.
- IDLE: busy=0. On start=1: SR ← {0, bin}, cnt ← WIDTH, ovf_r ← 0, state → SHIFT.
- SHIFT: busy=1. Each edge: (1) each BCD nibble ≥5 gets +3 (all nibbles in parallel, based on the current SR value), (2) the adjusted SR shifts left by 1, (3) the bit shifted out of the top nibble is ORed into ovf_r, (4) cnt decrements.
- On the edge where cnt goes 1→0: bcd ← BCD field of the shifted SR, ovf ← ovf_r OR the final shifted-out bit, lz_mask computed from the new bcd, done ← 1, state → IDLE.
- done is cleared on every other edge. bcd/ovf/lz_mask hold their value until the next done.
- start while busy is ignored and is not queued. start during the done cycle is accepted (state is already IDLE).
- Adjustment is applied before each shift. No adjustment after the final shift.

## Timing
- Reset values: busy=0, done=0, bcd=0, ovf=0, lz_mask = all ones except bit 0 (consistent with value 0), state IDLE, SR=0, cnt=0.
- Reset asserted mid-conversion aborts it. No done is produced. Outputs return to their reset values on that edge.
- Latency: start is sampled at edge E0. Shifts occur on E1..E_WIDTH. done is high in the cycle after E_WIDTH, so WIDTH+1 edges from acceptance to result.
- busy is high from the cycle after E0 through the cycle ending at E_WIDTH. busy=0 while done=1.
- Maximum throughput is one conversion per WIDTH+1 cycles, by re-asserting start in the done cycle.

## Test plan
- WIDTH=11, DIGITS=4: bin=2047, pulse start -> done exactly 12 edges after acceptance; bcd=16'h2047, ovf=0, lz_mask=4'b0000.
- WIDTH=11, DIGITS=4: bin=0 -> bcd=16'h0000, ovf=0, lz_mask=4'b1110. bin=5 -> bcd=16'h0005, lz_mask=4'b1110. bin=90 -> bcd=16'h0090, lz_mask=4'b1100.
- WIDTH=11, DIGITS=3: bin=2047 -> bcd=12'h047, ovf=1. Then bin=999 -> bcd=12'h999, ovf=0.
- Start re-pulsed with bin=1 mid-conversion of 1234 -> ignored. Result is 16'h1234 and only one done pulse.
- start held high through the done cycle with bin changing 1234→56 -> second conversion accepted on the done edge. Results 16'h1234 then 16'h0056, 12 edges apart.
- Reset asserted 5 edges into converting 2047 -> on the next edge busy=0, done=0, bcd=0, ovf=0. No done appears afterwards. A fresh conversion after reset completes normally.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Start/done handshake with held bcd, overflow flag and leading-zero mask.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 11,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     lz_mask
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [DIGITS-1:0] LZ_RST =
    {DIGITS{1'b1}} ^ DIGITS'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state;
  logic [SW-1:0]   sr;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   nxt;
  logic [CW-1:0]   cnt;
  logic            ovf_r;
  logic            out_bit;
  logic [BW-1:0]   bcd_nxt;
  logic [DIGITS-1:0] lz_nxt;
  logic            allz;

  always_comb begin
    adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[WIDTH+4*i +: 4] >= 4'd5)
        adj[WIDTH+4*i +: 4] =
          sr[WIDTH+4*i +: 4] + 4'd3;
    end
  end

  assign nxt     = {adj[SW-2:0], 1'b0};
  assign out_bit = adj[SW-1];
  assign bcd_nxt = nxt[SW-1 -: BW];

  // Blank a digit only if it and every digit above it are zero.
  always_comb begin
    allz   = 1'b1;
    lz_nxt = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      allz = allz & (bcd_nxt[4*i +: 4] == 4'd0);
      if (i != 0)
        lz_nxt[i] = allz;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      ovf_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
      lz_mask <= LZ_RST;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sr    <= {{BW{1'b0}}, bin};
            cnt   <= CW'(WIDTH);
            ovf_r <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr    <= nxt;
          ovf_r <= ovf_r | out_bit;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd     <= bcd_nxt;
            ovf     <= ovf_r | out_bit;
            lz_mask <= lz_nxt;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: 4-digit and 3-digit instances,
// directed cases plus random start/bin traffic against an arithmetic model.
module tb_bin_to_bcd_seq;

  localparam int W = 11;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  lz;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic          s4 = 1'b0, s3 = 1'b0;
  logic [W-1:0]  b4 = '0, b3 = '0;
  logic          busy4, done4, ovf4;
  logic          busy3, done3, ovf3;
  logic [15:0]   bcd4;
  logic [11:0]   bcd3;
  logic [3:0]    lz4;
  logic [2:0]    lz3;

  exp_t q4[$];
  exp_t q3[$];
  int   ok4 = 0, ok3 = 0;
  int   cyc = 0;
  int   nchk = 0, nfail = 0;

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(4)) u4 (
    .clk(clk), .reset(reset), .start(s4), .bin(b4),
    .busy(busy4), .done(done4), .bcd(bcd4),
    .ovf(ovf4), .lz_mask(lz4)
  );

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(3)) u3 (
    .clk(clk), .reset(reset), .start(s3), .bin(b3),
    .busy(busy3), .done(done3), .bcd(bcd3),
    .ovf(ovf3), .lz_mask(lz3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(int v, int d, int due);
    exp_t e;
    int pw, m, dig;
    bit hz;
    pw = 1;
    for (int i = 0; i < d; i++) pw = pw * 10;
    m = v % pw;
    e.bcd = '0;
    e.lz  = '0;
    e.ovf = (v >= pw);
    e.due = due;
    hz = 1'b1;
    for (int i = d - 1; i >= 0; i--) begin
      int p;
      p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      dig = (m / p) % 10;
      e.bcd[4*i +: 4] = 4'(dig);
      hz = hz && (dig == 0);
      if (i > 0) e.lz[i] = hz;
    end
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Predictor: decides acceptance from the bench's own idle timeline.
  always @(posedge clk) begin
    if (reset) begin
      q4.delete();
      q3.delete();
      ok4 = 0;
      ok3 = 0;
    end else begin
      if (s4 && cyc + 1 >= ok4) begin
        q4.push_back(model(int'(b4), 4, cyc + 1 + W));
        ok4 = cyc + 2 + W;
      end
      if (s3 && cyc + 1 >= ok3) begin
        q3.push_back(model(int'(b3), 3, cyc + 1 + W));
        ok3 = cyc + 2 + W;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (done4) begin
        if (q4.size() == 0) begin
          chk("d4 unexpected done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q4.pop_front();
          chk("d4 bcd", 32'(bcd4), 32'(e.bcd));
          chk("d4 ovf", 32'(ovf4), 32'(e.ovf));
          chk("d4 lz_mask", 32'(lz4), 32'(e.lz));
          chk("d4 latency", 32'(cyc), 32'(e.due));
          chk("d4 busy in done", 32'(busy4), 32'd0);
        end
      end else begin
        if (q4.size() > 0 && cyc > q4[0].due) begin
          chk("d4 missing done", 32'(cyc), 32'(q4[0].due));
          void'(q4.pop_front());
        end
        chk("d4 busy", 32'(busy4),
            32'(q4.size() > 0 && cyc < q4[0].due));
      end
      if (done3) begin
        if (q3.size() == 0) begin
          chk("d3 unexpected done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q3.pop_front();
          chk("d3 bcd", 32'(bcd3), 32'(e.bcd[11:0]));
          chk("d3 ovf", 32'(ovf3), 32'(e.ovf));
          chk("d3 lz_mask", 32'(lz3), 32'(e.lz[2:0]));
          chk("d3 latency", 32'(cyc), 32'(e.due));
        end
      end else if (q3.size() > 0 && cyc > q3[0].due) begin
        chk("d3 missing done", 32'(cyc), 32'(q3[0].due));
        void'(q3.pop_front());
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse4(int v);
    b4 = W'(v);
    s4 = 1'b1;
    tick(1);
    s4 = 1'b0;
  endtask

  task automatic pulse3(int v);
    b3 = W'(v);
    s3 = 1'b1;
    tick(1);
    s3 = 1'b0;
  endtask

  initial begin
    tick(2);
    chk("rst busy", 32'(busy4), 32'd0);
    chk("rst done", 32'(done4), 32'd0);
    chk("rst bcd", 32'(bcd4), 32'd0);
    chk("rst ovf", 32'(ovf4), 32'd0);
    chk("rst lz_mask", 32'(lz4), 32'b1110);
    reset = 1'b0;
    tick(1);

    pulse4(2047);
    tick(W + 2);
    foreach (b3[i]) b3[i] = 1'b0;
    pulse4(0);
    tick(W + 2);
    pulse4(5);
    tick(W + 2);
    pulse4(90);
    tick(W + 2);

    pulse3(2047);
    tick(W + 2);
    pulse3(999);
    tick(W + 2);

    pulse4(1234);
    tick(4);
    pulse4(1);
    tick(W + 2);

    // held start: second value accepted on the done edge
    b4 = W'(1234);
    s4 = 1'b1;
    tick(1);
    b4 = W'(56);
    tick(W + 1);
    s4 = 1'b0;
    tick(W + 2);

    pulse4(2047);
    tick(4);
    reset = 1'b1;
    tick(1);
    chk("abort busy", 32'(busy4), 32'd0);
    chk("abort done", 32'(done4), 32'd0);
    chk("abort bcd", 32'(bcd4), 32'd0);
    chk("abort ovf", 32'(ovf4), 32'd0);
    reset = 1'b0;
    tick(W + 4);
    pulse4(407);
    tick(W + 2);

    for (int i = 0; i < 800; i++) begin
      s4 = ($urandom_range(0, 3) == 0);
      s3 = ($urandom_range(0, 2) == 0);
      b4 = W'($urandom_range(0, 2047));
      b3 = W'($urandom_range(0, 2047));
      tick(1);
    end
    s4 = 1'b0;
    s3 = 1'b0;
    tick(W + 4);
    chk("d4 drained", 32'(q4.size()), 32'd0);
    chk("d3 drained", 32'(q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
